// File: rtl/vertex_pkg.sv
// Shared defaults and arbiter state type for the vertex ROM read path.
package vertex_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int ADDR_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF  = 96;
    localparam int ROM_LATENCY_DEF = 2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: one-hot grant to the first request at or above
// the pointer, wrapping past the top index back to zero.
module rr_arbiter
    import vertex_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_in,
    input  logic [PTR_W-1:0] ptr_in,
    output logic [N-1:0]     grant_out
);

    int   idx;
    logic found;

    always_comb begin
        grant_out = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_in) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_in[idx]) begin
                grant_out[idx] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vertex_rom_arbiter.sv
// Shares one vertex ROM among several requesters: round-robin grant with an
// optional lock, registered ROM address, and a tag pipeline that routes each
// read's data back to its requester a fixed number of cycles later.
module vertex_rom_arbiter
    import vertex_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ-1:0]            req_lock_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [ADDR_WIDTH-1:0]         rom_addr_out,
    input  logic [DATA_WIDTH-1:0]         rom_data_in,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic [DATA_WIDTH-1:0]         resp_data_out,
    output logic                          busy_out
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                       state_q, state_d;
    logic [ID_W-1:0]                  ptr_q, ptr_d;
    logic [ID_W-1:0]                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]            rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY:0]             tag_valid_q, tag_valid_d;
    logic [ROM_LATENCY:0][ID_W-1:0]   tag_id_q, tag_id_d;
    logic [DATA_WIDTH-1:0]            resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0]               rr_grant;
    logic [NUM_REQ-1:0]               ready;
    logic [ID_W-1:0]                  grant_idx;
    logic                             accept;
    logic                             resp_any;

    function automatic logic [ID_W-1:0] wrap_next(input logic [ID_W-1:0] idx);
        return (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .req_in    (req_valid_in),
        .ptr_in    (ptr_q),
        .grant_out (rr_grant)
    );

    // While locked only the owner can be granted, and only when it is valid.
    always_comb begin
        ready = '0;
        if (!rst_in) begin
            if (state_q == ARB_IDLE) begin
                ready = rr_grant;
            end else begin
                ready[owner_q] = req_valid_in[owner_q];
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign accept        = |(ready & req_valid_in);
    assign req_ready_out = ready;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        rom_addr_d     = rom_addr_q;
        tag_valid_d[0] = accept;
        tag_id_d[0]    = grant_idx;
        for (int i = 1; i <= ROM_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end

        if (accept) begin
            rom_addr_d = req_addr_in[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            if (state_q == ARB_IDLE) begin
                ptr_d = wrap_next(grant_idx);
                if (req_lock_in[grant_idx]) begin
                    state_d = ARB_LOCKED;
                    owner_d = grant_idx;
                end
            end else if (!req_lock_in[owner_q]) begin
                state_d = ARB_IDLE;
                ptr_d   = wrap_next(owner_q);
            end
        end else if (state_q == ARB_LOCKED) begin
            // Owner went invalid: the lock is abandoned without moving the pointer.
            state_d = ARB_IDLE;
        end
    end

    // Data is forwarded straight from the ROM in the response cycle; the held
    // copy only keeps the output stable between responses.
    assign resp_any      = tag_valid_q[ROM_LATENCY];
    assign resp_data_d   = resp_any ? rom_data_in : resp_data_q;
    assign resp_data_out = resp_any ? rom_data_in : resp_data_q;

    always_comb begin
        resp_valid_out = '0;
        if (resp_any) begin
            resp_valid_out[tag_id_q[ROM_LATENCY]] = 1'b1;
        end
    end

    assign rom_addr_out = rom_addr_q;
    assign busy_out     = (state_q == ARB_LOCKED) || (|tag_valid_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rom_addr_q  <= '0;
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            rom_addr_q  <= rom_addr_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_vertex_rom_arbiter.sv
// Directed bench for vertex_rom_arbiter with a two-cycle ROM model whose word
// at address a is {a, a+1, a+2}, each field zero-extended to 32 bits.
module tb_vertex_rom_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_WIDTH  = 16;
    localparam int DATA_WIDTH  = 96;
    localparam int ROM_LATENCY = 2;

    logic                          clk_in;
    logic                          rst_in;
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ-1:0]            req_lock_in;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [ADDR_WIDTH-1:0]         rom_addr_out;
    logic [DATA_WIDTH-1:0]         rom_data_in;
    logic [NUM_REQ-1:0]            resp_valid_out;
    logic [DATA_WIDTH-1:0]         resp_data_out;
    logic                          busy_out;

    logic [ADDR_WIDTH-1:0]         rom_s1;
    logic [DATA_WIDTH-1:0]         rom_s2;

    int tests_run;
    int tests_failed;

    vertex_rom_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .ROM_LATENCY (ROM_LATENCY)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_lock_in    (req_lock_in),
        .req_addr_in    (req_addr_in),
        .req_ready_out  (req_ready_out),
        .rom_addr_out   (rom_addr_out),
        .rom_data_in    (rom_data_in),
        .resp_valid_out (resp_valid_out),
        .resp_data_out  (resp_data_out),
        .busy_out       (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] x;
        x = {16'h0000, a};
        return {x, x + 32'd1, x + 32'd2};
    endfunction

    // Address registered by the DUT, then two ROM cycles to data.
    always @(posedge clk_in) begin
        rom_s1 <= rom_addr_out;
        rom_s2 <= rom_word(rom_s1);
    end
    assign rom_data_in = rom_s2;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ-1:0] lock);
        req_valid_in = valid;
        req_lock_in  = lock;
        #1;
    endtask

    task automatic setAddr(input int idx, input logic [ADDR_WIDTH-1:0] value);
        req_addr_in[idx*ADDR_WIDTH +: ADDR_WIDTH] = value;
    endtask

    task automatic stepCycle();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_resp;

        tests_run    = 0;
        tests_failed = 0;
        rst_in       = 1'b1;
        req_valid_in = '0;
        req_lock_in  = '0;
        req_addr_in  = '0;

        // Reset state, with requests present while reset is held.
        #2;
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("reset_ready", req_ready_out, 4'b0000);
        checkOutput("reset_busy", busy_out, 1'b0);
        checkOutput("reset_rom_addr", rom_addr_out, 16'h0000);
        checkOutput("reset_resp_valid", resp_valid_out, 4'b0000);
        checkOutput("reset_resp_data", resp_data_out, 96'h0);
        applyStimulus(4'b0000, 4'b0000);
        stepCycle();
        stepCycle();
        rst_in = 1'b0;

        // Single request from requester 1.
        setAddr(1, 16'h0005);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("single_ready", req_ready_out, 4'b0010);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_rom_addr", rom_addr_out, 16'h0005);
        checkOutput("single_busy", busy_out, 1'b1);
        stepCycle();
        checkOutput("single_resp_early", resp_valid_out, 4'b0000);
        stepCycle();
        checkOutput("single_resp_valid", resp_valid_out, 4'b0010);
        checkOutput("single_resp_data", resp_data_out, rom_word(16'h0005));
        stepCycle();
        checkOutput("single_busy_done", busy_out, 1'b0);
        applyStimulus(4'b1101, 4'b0000);
        checkOutput("single_ptr_is_2", req_ready_out, 4'b0100);
        applyStimulus(4'b0000, 4'b0000);

        // Contention from pointer 0: grants 0,1,2,3,0, responses 3 cycles later.
        rst_in = 1'b1;
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            setAddr(i, 16'(16'h0010 + i));
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus((k <= 4) ? 4'b1111 : 4'b0000, 4'b0000);
            exp_ready = (k <= 4) ? (4'b0001 << (k % 4)) : 4'b0000;
            checkOutput($sformatf("cont_ready_k%0d", k), req_ready_out, exp_ready);
            if (k >= 1 && k <= 5) begin
                checkOutput($sformatf("cont_rom_addr_k%0d", k), rom_addr_out,
                            16'(16'h0010 + ((k - 1) % 4)));
            end
            if (k >= 3) begin
                exp_resp = 4'b0001 << ((k - 3) % 4);
                checkOutput($sformatf("cont_resp_k%0d", k), resp_valid_out, exp_resp);
                checkOutput($sformatf("cont_data_k%0d", k), resp_data_out,
                            rom_word(16'(16'h0010 + ((k - 3) % 4))));
            end
            stepCycle();
        end
        checkOutput("cont_busy_done", busy_out, 1'b0);

        // Lock triple: pointer is 1, requester 2 holds three beats before 0.
        setAddr(2, 16'h0020);
        setAddr(0, 16'h0030);
        applyStimulus(4'b0101, 4'b0100);
        checkOutput("lock_beat1", req_ready_out, 4'b0100);
        stepCycle();
        applyStimulus(4'b0101, 4'b0100);
        checkOutput("lock_beat2", req_ready_out, 4'b0100);
        checkOutput("lock_busy1", busy_out, 1'b1);
        stepCycle();
        applyStimulus(4'b0101, 4'b0000);
        checkOutput("lock_beat3", req_ready_out, 4'b0100);
        stepCycle();
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("lock_then_req0", req_ready_out, 4'b0001);
        checkOutput("lock_resp1", resp_valid_out, 4'b0100);
        checkOutput("lock_data1", resp_data_out, rom_word(16'h0020));
        stepCycle();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("lock_resp2", resp_valid_out, 4'b0100);
        checkOutput("lock_busy2", busy_out, 1'b1);
        stepCycle();
        checkOutput("lock_resp3", resp_valid_out, 4'b0100);
        checkOutput("lock_busy3", busy_out, 1'b1);
        stepCycle();
        checkOutput("lock_resp_req0", resp_valid_out, 4'b0001);
        checkOutput("lock_data_req0", resp_data_out, rom_word(16'h0030));
        checkOutput("lock_busy_last", busy_out, 1'b1);
        stepCycle();
        checkOutput("lock_busy_done", busy_out, 1'b0);

        // Lock abandon: owner 3 drops valid, request 0 granted after return to idle.
        setAddr(3, 16'h0040);
        setAddr(0, 16'h0050);
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("abandon_lock_grant", req_ready_out, 4'b1000);
        stepCycle();
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("abandon_locked_block", req_ready_out, 4'b0000);
        checkOutput("abandon_busy", busy_out, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("abandon_req0_grant", req_ready_out, 4'b0001);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("abandon_resp3", resp_valid_out, 4'b1000);
        checkOutput("abandon_data3", resp_data_out, rom_word(16'h0040));
        stepCycle();
        checkOutput("abandon_no_resp", resp_valid_out, 4'b0000);
        stepCycle();
        checkOutput("abandon_resp0", resp_valid_out, 4'b0001);
        checkOutput("abandon_data0", resp_data_out, rom_word(16'h0050));
        stepCycle();

        // Reset with two reads in flight.
        setAddr(1, 16'h0060);
        setAddr(2, 16'h0070);
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("rst_beat1", req_ready_out, 4'b0010);
        stepCycle();
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("rst_beat2", req_ready_out, 4'b0100);
        stepCycle();
        rst_in = 1'b1;
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("rst_ready_low", req_ready_out, 4'b0000);
        checkOutput("rst_busy_low", busy_out, 1'b0);
        checkOutput("rst_rom_addr", rom_addr_out, 16'h0000);
        checkOutput("rst_resp_low", resp_valid_out, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        stepCycle();
        rst_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("rst_no_resp_%0d", k), resp_valid_out, 4'b0000);
            checkOutput($sformatf("rst_no_busy_%0d", k), busy_out, 1'b0);
            stepCycle();
        end
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("rst_ptr_zero", req_ready_out, 4'b0001);
        applyStimulus(4'b0000, 4'b0000);

        // Idle hold after a single beat at 0x00AB.
        setAddr(0, 16'h00AB);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("hold_grant", req_ready_out, 4'b0001);
        stepCycle();
        applyStimulus(4'b0000, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("hold_addr_%0d", k), rom_addr_out, 16'h00AB);
            checkOutput($sformatf("hold_resp_%0d", k), resp_valid_out,
                        (k == 2) ? 4'b0001 : 4'b0000);
            if (k == 2) begin
                checkOutput("hold_data", resp_data_out, rom_word(16'h00AB));
            end
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
